mux2_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 2-bit `mux2` datapath in the microprocessor.
- Two requesters (A, B) compete for the single 2-bit result path.
- The block grants one owner at a time, drives `Sel` of the `mux2` instance and registers its output.
- It bounds how long one owner may hold the path while the other waits.
- It sits between the two operand producers and the downstream consumer of `Result`.

---
 rtl/mux2_arb_pkg.sv | 25 ++
 rtl/mux2_arbiter_if.sv | 24 ++
 rtl/mux2.sv | 11 +
 rtl/mux2_arbiter.sv | 111 +++++++++++
 tb/tb_mux2_arbiter.sv | 131 +++++++++++++
 5 files changed

// File: rtl/mux2_arb_pkg.sv
// Shared definitions for the mux2 round-robin arbiter.
package mux2_arb_pkg;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_OWN_A = 2'b01;
  localparam logic [1:0] S_OWN_B = 2'b10;

  localparam int unsigned DefaultMaxHold = 4;
  localparam int unsigned HoldWidth      = 4;

  typedef enum logic [1:0] {
    StIdle = S_IDLE,
    StOwnA = S_OWN_A,
    StOwnB = S_OWN_B
  } state_e;

  typedef logic [HoldWidth-1:0] hold_t;

  // Identifies the most recently served requester.
  typedef enum logic {
    SideA = 1'b0,
    SideB = 1'b1
  } side_e;

endpackage

// File: rtl/mux2_arbiter_if.sv
// Requester/consumer bundle around the shared mux2 result path.
interface mux2_arbiter_if;
  logic       ReqA;
  logic [1:0] DataA;
  logic       ReqB;
  logic [1:0] DataB;
  logic       GntA;
  logic       GntB;
  logic       Sel;
  logic [1:0] Result;
  logic       Valid;

  // Requesters and consumer side.
  modport master (
    output ReqA, DataA, ReqB, DataB,
    input  GntA, GntB, Sel, Result, Valid
  );

  // Arbiter side.
  modport slave (
    input  ReqA, DataA, ReqB, DataB,
    output GntA, GntB, Sel, Result, Valid
  );
endinterface

// File: rtl/mux2.sv
// Existing 2:1 multiplexer for the 2-bit datapath; sel_i=0 picks d0_i.
module mux2 #(
  parameter int unsigned Width = 2
) (
  input  logic [Width-1:0] d0_i,
  input  logic [Width-1:0] d1_i,
  input  logic             sel_i,
  output logic [Width-1:0] y_o
);
  assign y_o = sel_i ? d1_i : d0_i;
endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter for the shared mux2 path with bounded hold time.
// MAX_HOLD must lie in 1..15.
module mux2_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DefaultMaxHold
) (
  input logic          clk,
  input logic          rst_n,
  mux2_arbiter_if.slave bus
);

  localparam hold_t HoldLast = HoldWidth'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  hold_t      hold_q, hold_d;
  side_e      last_q, last_d;
  logic       sel_q, sel_d;
  logic [1:0] result_q, result_d;
  logic       valid_q, valid_d;
  logic [1:0] mux_y;

  mux2 #(
    .Width (2)
  ) u_mux2 (
    .d0_i  (bus.DataA),
    .d1_i  (bus.DataB),
    .sel_i (sel_q),
    .y_o   (mux_y)
  );

  // Next-state, hold counter, last-served side and datapath updates.
  always_comb begin
    state_d  = state_q;
    hold_d   = '0;
    last_d   = last_q;
    sel_d    = sel_q;
    result_d = result_q;
    valid_d  = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (bus.ReqA && bus.ReqB) begin
          state_d = (last_q == SideA) ? StOwnB : StOwnA;
        end else if (bus.ReqA) begin
          state_d = StOwnA;
        end else if (bus.ReqB) begin
          state_d = StOwnB;
        end
      end
      StOwnA: begin
        if (bus.ReqA && !(bus.ReqB && hold_q == HoldLast)) begin
          hold_d = (hold_q == HoldLast) ? hold_q : hold_q + 1'b1;
        end else if (bus.ReqB) begin
          state_d = StOwnB;
        end else begin
          state_d = StIdle;
        end
      end
      StOwnB: begin
        if (bus.ReqB && !(bus.ReqA && hold_q == HoldLast)) begin
          hold_d = (hold_q == HoldLast) ? hold_q : hold_q + 1'b1;
        end else if (bus.ReqA) begin
          state_d = StOwnA;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Sel follows the owner and is held through IDLE.
    if (state_d == StOwnA) begin
      sel_d  = 1'b0;
      last_d = SideA;
    end else if (state_d == StOwnB) begin
      sel_d  = 1'b1;
      last_d = SideB;
    end

    if (state_q != StIdle) begin
      result_d = mux_y;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      hold_q   <= '0;
      last_q   <= SideB;
      sel_q    <= 1'b0;
      result_q <= 2'b00;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      last_q   <= last_d;
      sel_q    <= sel_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.GntA   = (state_q == StOwnA);
  assign bus.GntB   = (state_q == StOwnB);
  assign bus.Sel    = sel_q;
  assign bus.Result = result_q;
  assign bus.Valid  = valid_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter (MAX_HOLD=4) with an expectation queue.
module tb_mux2_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  // Expected {GntA, GntB, Sel, Valid, Result[1:0]} after each edge.
  logic [5:0] exp_q[$];

  mux2_arbiter_if bus ();

  mux2_arbiter #(
    .MAX_HOLD (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag);
    logic [5:0] obs;
    logic [5:0] exp;
    obs = {bus.GntA, bus.GntB, bus.Sel, bus.Valid, bus.Result};
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s: scoreboard empty, observed=%b", tag, obs);
      return;
    end
    exp = exp_q.pop_front();
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed {gA,gB,sel,v,res}=%b expected=%b", tag, obs, exp);
    end
    checks++;
    assert (!(bus.GntA === 1'b1 && bus.GntB === 1'b1)) else begin
      failures++;
      $error("FAIL %s_excl: observed GntA=%b GntB=%b expected not both 1", tag, bus.GntA,
             bus.GntB);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, sample 1 time unit past the edge.
  task automatic step(input string tag, input logic rn, input logic ra, input logic [1:0] da,
                      input logic rb, input logic [1:0] db, input logic [5:0] exp);
    rst_n     = rn;
    bus.ReqA  = ra;
    bus.DataA = da;
    bus.ReqB  = rb;
    bus.DataB = db;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bus.ReqA  = 1'b1;
    bus.ReqB  = 1'b1;
    bus.DataA = 2'b01;
    bus.DataB = 2'b11;
    #2;

    // Reset with both requesting, then release: A wins the first tie.
    step("rst0",     1'b0, 1'b1, 2'b01, 1'b1, 2'b11, 6'b000000);
    step("rst1",     1'b0, 1'b1, 2'b01, 1'b1, 2'b11, 6'b000000);
    step("rel_a",    1'b1, 1'b1, 2'b01, 1'b1, 2'b11, 6'b100000);

    // Fairness: 4-cycle runs, Result lagging grant by one cycle.
    step("fair_a1",  1'b1, 1'b1, 2'b01, 1'b1, 2'b11, 6'b100101);
    step("fair_a2",  1'b1, 1'b1, 2'b01, 1'b1, 2'b11, 6'b100101);
    step("fair_a3",  1'b1, 1'b1, 2'b01, 1'b1, 2'b11, 6'b100101);
    step("fair_b0",  1'b1, 1'b1, 2'b01, 1'b1, 2'b11, 6'b011101);
    step("fair_b1",  1'b1, 1'b1, 2'b01, 1'b1, 2'b11, 6'b011111);
    step("fair_b2",  1'b1, 1'b1, 2'b01, 1'b1, 2'b11, 6'b011111);
    step("fair_b3",  1'b1, 1'b1, 2'b01, 1'b1, 2'b11, 6'b011111);
    step("fair_a0",  1'b1, 1'b1, 2'b01, 1'b1, 2'b11, 6'b100111);

    // Handover A->B without an idle cycle, then drain to IDLE.
    step("hand_b",   1'b1, 1'b0, 2'b01, 1'b1, 2'b11, 6'b011101);
    step("drain",    1'b1, 1'b0, 2'b01, 1'b0, 2'b11, 6'b001111);
    step("idle",     1'b1, 1'b0, 2'b01, 1'b0, 2'b11, 6'b001011);

    // Tie after idle: B last -> A wins; A last -> B wins.
    step("tie_a",    1'b1, 1'b1, 2'b01, 1'b1, 2'b11, 6'b100011);
    step("tie_gap",  1'b1, 1'b0, 2'b01, 1'b0, 2'b11, 6'b000101);
    step("tie_b",    1'b1, 1'b1, 2'b01, 1'b1, 2'b11, 6'b011001);

    // Reset while B owns at hold=2; next tie goes to A.
    step("own_b1",   1'b1, 1'b1, 2'b01, 1'b1, 2'b11, 6'b011111);
    step("own_b2",   1'b1, 1'b1, 2'b01, 1'b1, 2'b11, 6'b011111);
    step("mid_rst",  1'b0, 1'b1, 2'b01, 1'b1, 2'b11, 6'b000000);
    step("post_rst", 1'b1, 1'b1, 2'b01, 1'b1, 2'b11, 6'b100000);

    // Single requester A with DataA=10 from IDLE.
    step("sgl_drop", 1'b1, 1'b0, 2'b10, 1'b0, 2'b11, 6'b000110);
    step("sgl_idle", 1'b1, 1'b0, 2'b10, 1'b0, 2'b11, 6'b000010);
    step("sgl_gnt",  1'b1, 1'b1, 2'b10, 1'b0, 2'b11, 6'b100010);
    step("sgl_res",  1'b1, 1'b1, 2'b10, 1'b0, 2'b11, 6'b100110);
    step("sgl_res2", 1'b1, 1'b1, 2'b10, 1'b0, 2'b11, 6'b100110);
    step("sgl_rel",  1'b1, 1'b0, 2'b10, 1'b0, 2'b11, 6'b000110);
    step("sgl_end",  1'b1, 1'b0, 2'b10, 1'b0, 2'b11, 6'b000010);

    // Hold saturates while B is quiet; B then preempts on its first request.
    step("sat_gnt",  1'b1, 1'b1, 2'b10, 1'b0, 2'b11, 6'b100010);
    for (int i = 0; i < 5; i++) begin
      step("sat_hold", 1'b1, 1'b1, 2'b10, 1'b0, 2'b11, 6'b100110);
    end
    step("sat_pre",  1'b1, 1'b1, 2'b10, 1'b1, 2'b11, 6'b011110);
    step("sat_b",    1'b1, 1'b1, 2'b10, 1'b1, 2'b11, 6'b011111);

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL sb_drain: observed %0d leftover entries expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
